// File: rtl/mem_access_unit_if.sv
// Bundle of request, response and memory-side signals for mem_access_unit.
// master = requester plus attached memory, slave = the access unit itself.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // A request transfers on a rising edge where req_valid && req_ready are both high;
  // req_ready is high only while the unit is idle, and rsp_valid is a one-cycle pulse.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] mem_A;
  logic [DATA_WIDTH-1:0] mem_WD;
  logic                  mem_WE;
  logic [DATA_WIDTH-1:0] mem_RD;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_RD,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_RD,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator: byte/half/word accesses to a word-addressed memory,
// sub-word stores done as read-modify-write, loads returned aligned and extended.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 100
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state, state_nxt;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] load_data;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;

  always_comb begin
    req_err = 1'b0;
    if (bus.req_size == 2'b11)                            req_err = 1'b1;
    if (bus.req_size == 2'b01 && bus.req_addr[0])         req_err = 1'b1;
    if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ((bus.req_addr >> 2) >= ADDR_WIDTH'(MEM_DEPTH))    req_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      word_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.req_valid) begin
        we_q     <= bus.req_we;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        err_q    <= req_err;
      end
      if (state == READ) word_q <= bus.mem_RD;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)                     state_nxt = RESP;
          else if (!bus.req_we)            state_nxt = READ;
          else if (bus.req_size == 2'b10)  state_nxt = WRITE;
          else                             state_nxt = READ;
        end
      end
      READ:    state_nxt = we_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Little-endian lanes: the byte offset selects the bit position directly.
  always_comb begin
    merged = word_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign lane_b = word_q[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = word_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'b00:   load_data = signed_q ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
      2'b01:   load_data = signed_q ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
      default: load_data = word_q;
    endcase
  end

  // Outputs are decoded from state so reset removes a write strobe at once.
  assign bus.req_ready = (state == IDLE);
  assign bus.mem_WE    = (state == WRITE);
  assign bus.mem_WD    = (state == WRITE) ? merged : '0;
  assign bus.mem_A     = addr_q >> 2;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = (state == RESP) && err_q;
  assign bus.rsp_rdata = (state == RESP && !err_q && !we_q) ? load_data : '0;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: attached memory model, directed and random requests,
// expectations from a word-array reference model compared by decoupled monitors.
module tb_mem_access_unit;
  localparam int DEPTH = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_init;
  logic [1:0] state_dbg;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus();

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];
  logic [31:0] wr_idx_q[$];
  logic [31:0] wr_data_q[$];
  int          acc_q[$];

  function automatic logic [31:0] seed(input int i);
    return 32'h1234_5678 ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  // Attached memory: combinational read, write on the rising edge.
  assign bus.mem_RD = (bus.mem_A < DEPTH) ? mem[bus.mem_A[6:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seed(i);
    end else if (bus.mem_WE && bus.mem_A < DEPTH) begin
      mem[bus.mem_A[6:0]] <= bus.mem_WD;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event not expected by the model (t=%0t)", name, $time);
  endtask

  // Acceptance monitor: records the cycle number of each accepting edge.
  always @(negedge clk) begin
    if (rst && bus.req_valid && bus.req_ready) acc_q.push_back(cyc + 1);
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        note_fail("unexpected_rsp");
      end else begin
        check("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err_q.pop_front()));
        if (acc_q.size() == 0) note_fail("rsp_without_accept");
        else check("latency", 32'(cyc - acc_q.pop_front() + 1), 32'(exp_lat_q.pop_front()));
      end
    end
  end

  // Write monitor.
  always @(negedge clk) begin
    if (rst && bus.mem_WE) begin
      if (wr_idx_q.size() == 0) begin
        note_fail("unexpected_mem_we");
      end else begin
        check("mem_A", bus.mem_A, wr_idx_q.pop_front());
        check("mem_WD", bus.mem_WD, wr_data_q.pop_front());
      end
    end
  end

  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] w, v, nw, mask;
    int idx, sh;
    logic err;
    idx = int'(addr >> 2);
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
          (size == 2'd2 && addr[1:0] != 2'd0) || ((addr >> 2) >= DEPTH);
    if (err) begin
      exp_q.push_back(32'h0); exp_err_q.push_back(1'b1); exp_lat_q.push_back(1);
    end else if (!we) begin
      w = ref_mem[idx];
      if (size == 2'd0) begin
        v = (w >> (8 * int'(addr[1:0]))) & 32'hFF;
        if (sgn && v >= 32'd128) v = v - 32'd256;
      end else if (size == 2'd1) begin
        v = (w >> (16 * int'(addr[1]))) & 32'hFFFF;
        if (sgn && v >= 32'd32768) v = v - 32'd65536;
      end else begin
        v = w;
      end
      exp_q.push_back(v); exp_err_q.push_back(1'b0); exp_lat_q.push_back(2);
    end else begin
      w = ref_mem[idx];
      if (size == 2'd2) begin
        nw = wdata;
        exp_lat_q.push_back(2);
      end else begin
        sh   = (size == 2'd0) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
        mask = (size == 2'd0) ? 32'hFF : 32'hFFFF;
        nw   = (w & ~(mask << sh)) | ((wdata & mask) << sh);
        exp_lat_q.push_back(3);
      end
      ref_mem[idx] = nw;
      wr_idx_q.push_back(32'(idx));
      wr_data_q.push_back(nw);
      exp_q.push_back(32'h0); exp_err_q.push_back(1'b0);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic hold);
    int n;
    model(we, size, sgn, addr, wdata);
    @(posedge clk); #1;
    bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
      if (n > 20) begin
        note_fail("req_ready_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) note_fail("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; mem_init = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_mem_WE", 32'(bus.mem_WE), 32'd0);
    check("rst_mem_WD", bus.mem_WD, 32'h0);
    check("rst_mem_A", bus.mem_A, 32'h0);
    check("rst_state", 32'(state_dbg), 32'd0);
    mem_init = 1'b0;
    rst = 1'b1;

    // Reset during WRITE of a word store to address 0.
    wr_idx_q.push_back(32'h0); wr_data_q.push_back(32'h0000_0055);
    @(posedge clk); #1;
    bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0000_0055; bus.req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_WE) break;
      n++;
      if (n > 10) begin
        note_fail("mem_WE_timeout");
        break;
      end
    end
    bus.req_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("abort_mem_WE", 32'(bus.mem_WE), 32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    acc_q.delete();
    repeat (3) @(negedge clk);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_word0", mem[0], ref_mem[0]);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);

    // Word store / load, byte read-modify-write, extension cases.
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 32'h9, 32'h0000_00AA, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 32'h9, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h9, 32'h0, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 1'b0);

    // Errors: misaligned word, out of range, illegal size, misaligned half.
    do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1'b0);
    do_req(1'b1, 2'd2, 1'b0, 32'h190, 32'h1234_5678, 1'b0);
    do_req(1'b0, 2'd3, 1'b0, 32'h4, 32'h0, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 32'h18C, 32'h77, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 32'h18E, 32'hBEEF, 1'b0);
    drain();

    // Back-to-back word loads with req_valid held high.
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    drain();

    // Random traffic over the top of memory and just past it.
    for (int i = 0; i < 120; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 32'h1A0)), $urandom, 1'b0);
    end
    drain();

    for (int i = 0; i < DEPTH; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    if (wr_idx_q.size() != 0) note_fail("missing_mem_writes");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
